// File: rtl/fpu_seq.sv
// Issue sequencer for the shared double-precision FPU: accepts one op, starts the
// datapath, waits the op's fixed latency, then hands the result to writeback.
module fpu_seq #(
    parameter int XLEN     = 64,
    parameter int LAT_ADD  = 4,
    parameter int LAT_MUL  = 5,
    parameter int LAT_DIV  = 20,
    parameter int LAT_SQRT = 24,
    parameter int LAT_CVT  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [4:0]      in_rd,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            fpu_start,
    output logic [2:0]      fpu_op,
    output logic [XLEN-1:0] fpu_a,
    output logic [XLEN-1:0] fpu_b,
    input  logic [XLEN-1:0] fpu_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [4:0]      out_rd,
    output logic            out_illegal,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_r;
    logic [5:0] cnt_r;

    // Cycles from the start pulse to the cycle in which the result is sampled.
    function automatic logic [5:0] op_lat(input logic [2:0] op);
        case (op)
            3'b000, 3'b001: op_lat = 6'(LAT_ADD);
            3'b010:         op_lat = 6'(LAT_MUL);
            3'b011:         op_lat = 6'(LAT_DIV);
            3'b100:         op_lat = 6'(LAT_SQRT);
            3'b101, 3'b110: op_lat = 6'(LAT_CVT);
            default:        op_lat = 6'd0;
        endcase
    endfunction

    assign in_ready = (state_r == IDLE) && !flush && !rst;

    // Sequencer state, latency counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= 6'd0;
            fpu_start   <= 1'b0;
            fpu_op      <= 3'd0;
            fpu_a       <= '0;
            fpu_b       <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_rd      <= 5'd0;
            out_illegal <= 1'b0;
            busy        <= 1'b0;
        end else if (flush) begin
            // Abort whatever is in flight; any pending result is dropped.
            state_r   <= IDLE;
            fpu_start <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            fpu_start <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        fpu_op <= in_op;
                        fpu_a  <= in_a;
                        fpu_b  <= in_b;
                        out_rd <= in_rd;
                        busy   <= 1'b1;
                        if (in_op == 3'b111) begin
                            state_r     <= DONE;
                            out_valid   <= 1'b1;
                            out_illegal <= 1'b1;
                            out_data    <= '0;
                        end else begin
                            state_r     <= EXEC;
                            cnt_r       <= op_lat(in_op);
                            fpu_start   <= 1'b1;
                            out_illegal <= 1'b0;
                        end
                    end
                end
                EXEC: begin
                    if (cnt_r == 6'd0) begin
                        out_data  <= fpu_result;
                        out_valid <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        cnt_r <= cnt_r - 6'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_seq.sv
// Randomized bench for fpu_seq: a transaction-level model predicts start pulse,
// completion cycle, sampled result and handshake behaviour for each issued op.
module tb_fpu_seq;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [2:0]  in_op;
    logic [4:0]  in_rd;
    logic [63:0] in_a, in_b;
    logic        fpu_start;
    logic [2:0]  fpu_op;
    logic [63:0] fpu_a, fpu_b, fpu_result;
    logic        out_valid, out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic        out_illegal, busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int lat_tab [8] = '{4, 4, 5, 20, 24, 2, 2, 0};

    fpu_seq dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
        .in_a(in_a), .in_b(in_b),
        .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_result(fpu_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd(out_rd), .out_illegal(out_illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    // Cycle index; the datapath result is a distinct value in every cycle.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] mix(input int c);
        logic [31:0] cc;
        cc = c;
        return {cc * 32'h9E37_79B1, cc ^ 32'hA5A5_5A5A};
    endfunction

    assign fpu_result = mix(cyc);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_start"}, fpu_start, 0);
        chk({tag, "_op"}, fpu_op, 0);
        chk({tag, "_a"}, fpu_a, 0);
        chk({tag, "_b"}, fpu_b, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_rd"}, out_rd, 0);
        chk({tag, "_ill"}, out_illegal, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Issue one op, follow it to completion, hold writeback off for 'stall' cycles.
    task automatic do_op(input logic [2:0] op, input logic [4:0] rd,
                         input logic [63:0] a, input logic [63:0] b, input int stall);
        int t0, seen, starts, exp_lat;
        logic [63:0] exp_data;
        @(negedge clk);
        chk("ready_idle", in_ready, 1);
        in_valid = 1'b1; in_op = op; in_rd = rd; in_a = a; in_b = b;
        out_ready = (stall == 0);
        t0 = cyc;
        exp_lat  = (op == 3'b111) ? 1 : lat_tab[op] + 2;
        exp_data = (op == 3'b111) ? 64'd0 : mix(t0 + 1 + lat_tab[op]);
        @(negedge clk);
        in_valid = 1'b0; in_op = 3'($urandom); in_a = {$urandom, $urandom}; in_b = ~in_a;
        chk("start_c1", fpu_start, (op != 3'b111));
        chk("fpu_op", fpu_op, op);
        chk("fpu_a", fpu_a, a);
        chk("fpu_b", fpu_b, b);
        chk("busy_c1", busy, 1);
        chk("ready_busy", in_ready, 0);
        seen = -1;
        starts = 0;
        for (int k = 0; k < 80 && seen < 0; k++) begin
            if (k > 0) @(negedge clk);
            if (out_valid) begin
                seen = cyc;
            end else begin
                if (k > 0) starts += int'(fpu_start);
                in_valid = 1'($urandom);
            end
        end
        chk("latency", seen - t0, exp_lat);
        chk("extra_start", starts, 0);
        chk("out_data", out_data, exp_data);
        chk("out_rd", out_rd, rd);
        chk("out_illegal", out_illegal, (op == 3'b111));
        for (int s = 1; s <= stall; s++) begin
            in_valid = 1'($urandom);
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, exp_data);
            chk("hold_rd", out_rd, rd);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("post_valid", out_valid, 0);
        chk("post_busy", busy, 0);
        chk("post_start", fpu_start, 0);
        chk("post_ready", in_ready, 1);
    endtask

    // Issue an op, flush it k cycles after the start cycle, confirm nothing emerges.
    task automatic flush_mid(input logic [2:0] op, input int k);
        int nvalid;
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_rd = 5'd9; in_a = {$urandom, $urandom}; in_b = 64'd1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (k) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_busy", busy, 0);
        chk("flush_valid", out_valid, 0);
        chk("flush_start", fpu_start, 0);
        chk("flush_ready", in_ready, 1);
        nvalid = 0;
        out_ready = 1'b1;
        repeat (30) begin
            @(negedge clk);
            nvalid += int'(out_valid);
        end
        chk("flush_no_valid", nvalid, 0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_rd = 5'd0;
        in_a = 64'd0; in_b = 64'd0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        chk("reset_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", in_ready, 1);

        do_op(3'b000, 5'd7, 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 0);
        do_op(3'b011, 5'd12, 64'h4024_0000_0000_0000, 64'h4008_0000_0000_0000, 3);
        do_op(3'b111, 5'd5, 64'hDEAD_BEEF_0000_0001, 64'd3, 0);
        flush_mid(3'b100, 14);
        do_op(3'b101, 5'd20, 64'h0000_0000_0000_002A, 64'd0, 1);

        // Reset in the middle of an fmul.
        @(negedge clk);
        in_valid = 1'b1; in_op = 3'b010; in_rd = 5'd31; in_a = 64'h1234; in_b = 64'h5678;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("midrst");
        rst = 1'b0;
        #1;
        chk("midrst_ready", in_ready, 1);

        // Flush and issue together in IDLE: the flush wins.
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_op = 3'b000;
        #1;
        chk("flush_vs_valid_ready", in_ready, 0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_vs_valid_busy", busy, 0);
        chk("flush_vs_valid_start", fpu_start, 0);

        for (int i = 0; i < 30; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            if (i % 6 == 5)
                flush_mid(op, $urandom_range(0, lat_tab[op] + 2));
            else
                do_op(op, 5'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                      $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
